// File: rtl/fa4_fetch_unit.sv
// fa4_fetch_unit: instruction fetch stage of the 0xFA4 CPU.
//
// Reads 1- or 2-byte instructions from a byte-wide, combinational-read
// instruction memory, keeps the program counter, and hands each complete
// instruction to decode/execute through a valid/ready handshake. Bit
// LONG_BIT of the opcode marks a 2-byte instruction. Fetch stops after a
// HALT_OPCODE bundle is accepted; only a redirect or reset restarts it.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   mem_re, mem_addr  read strobe and byte address to instruction memory
//   mem_data          read data, valid in the same cycle as mem_addr
//   instr_valid       bundle (opcode/operand/pc/long) is valid
//   instr_ready       downstream consumes the bundle this cycle
//   instr_opcode      first instruction byte
//   instr_operand     second byte, 0 for 1-byte instructions
//   instr_pc          address of the opcode byte
//   instr_long        1 = 2-byte instruction
//   redirect_valid    load redirect_pc as the new PC this cycle
//   redirect_pc       redirect target
//   halted            fetch stopped after delivering HALT_OPCODE
module fa4_fetch_unit #(
  parameter int                AW          = 8,
  parameter int                DW          = 8,
  parameter logic [AW-1:0]     RESET_PC    = '0,
  parameter logic [DW-1:0]     HALT_OPCODE = 8'hFF,
  parameter int                LONG_BIT    = 7
) (
  input  logic          clock,
  input  logic          reset,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_opcode,
  output logic [DW-1:0] instr_operand,
  output logic [AW-1:0] instr_pc,
  output logic          instr_long,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_FETCH_OP  = 2'd0,
    S_FETCH_ARG = 2'd1,
    S_ISSUE     = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic          r_mem_re;
  logic          r_valid;
  logic [DW-1:0] r_opcode;
  logic [DW-1:0] r_operand;
  logic [AW-1:0] r_instr_pc;
  logic          r_long;
  logic          r_halted;

  // Modular PC step; wrap from the top address back to 0 is intended.
  logic [AW-1:0] w_pc_next;
  assign w_pc_next = r_pc + AW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_FETCH_OP;
      r_pc       <= RESET_PC;
      r_mem_re   <= 1'b1;
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_instr_pc <= '0;
      r_long     <= 1'b0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything but reset: any partial or pending
      // bundle is dropped and a pending halt is cancelled.
      r_state  <= S_FETCH_OP;
      r_pc     <= redirect_pc;
      r_mem_re <= 1'b1;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH_OP: begin
          r_opcode   <= mem_data;
          r_instr_pc <= r_pc;
          r_pc       <= w_pc_next;
          if (mem_data[LONG_BIT]) begin
            r_state  <= S_FETCH_ARG;
            r_mem_re <= 1'b1;
          end else begin
            r_operand <= '0;
            r_long    <= 1'b0;
            r_state   <= S_ISSUE;
            r_mem_re  <= 1'b0;
            r_valid   <= 1'b1;
          end
        end
        S_FETCH_ARG: begin
          r_operand <= mem_data;
          r_long    <= 1'b1;
          r_pc      <= w_pc_next;
          r_state   <= S_ISSUE;
          r_mem_re  <= 1'b0;
          r_valid   <= 1'b1;
        end
        S_ISSUE: begin
          // Bundle registers are left untouched while stalled.
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (r_opcode == HALT_OPCODE) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
              r_mem_re <= 1'b0;
            end else begin
              r_state  <= S_FETCH_OP;
              r_mem_re <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          r_mem_re <= 1'b0;
          r_valid  <= 1'b0;
        end
        default: begin
          r_state  <= S_FETCH_OP;
          r_mem_re <= 1'b1;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_re        = r_mem_re;
  assign mem_addr      = r_pc;
  assign instr_valid   = r_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_pc      = r_instr_pc;
  assign instr_long    = r_long;
  assign halted        = r_halted;

endmodule

// File: tb/tb_fa4_fetch_unit.sv
// Bench for fa4_fetch_unit: directed scenarios with literal expectations,
// then randomized memory/ready/redirect/reset traffic checked every cycle
// against an instruction-level reference model.
module tb_fa4_fetch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       instr_valid;
  logic       instr_ready = 1'b1;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       instr_long;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       halted;

  logic [7:0] mem [256];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  assign mem_data = mem[mem_addr];

  fa4_fetch_unit #(
    .AW(8), .DW(8), .RESET_PC(8'h00), .HALT_OPCODE(8'hFF), .LONG_BIT(7)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_pc(instr_pc), .instr_long(instr_long),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: tracks the start address of the instruction being
  // worked on and how many cycles have elapsed since its opcode fetch.
  // A instruction of length n occupies n fetch cycles, then is offered
  // until accepted.
  logic [7:0] m_pc    = 8'h00;
  int         m_age   = 0;
  bit         m_halt  = 1'b0;
  bit         m_known = 1'b0;

  always @(negedge clock) begin
    int         len;
    logic [7:0] opc;
    logic [7:0] a;
    if (reset) begin
      m_known = 1'b1;
      m_pc    = 8'h00;
      m_age   = 0;
      m_halt  = 1'b0;
    end else if (m_known) begin
      opc = mem[m_pc];
      len = opc[7] ? 2 : 1;
      if (m_halt) begin
        chk("m_halted", halted, 1);
        chk("m_valid_halt", instr_valid, 0);
        chk("m_re_halt", mem_re, 0);
        chk("m_addr_halt", mem_addr, m_pc);
      end else if (m_age < len) begin
        a = m_pc + 8'(m_age);
        chk("m_valid_fetch", instr_valid, 0);
        chk("m_re_fetch", mem_re, 1);
        chk("m_addr_fetch", mem_addr, a);
        chk("m_halted_fetch", halted, 0);
      end else begin
        a = m_pc + 8'(len);
        chk("m_valid_issue", instr_valid, 1);
        chk("m_re_issue", mem_re, 0);
        chk("m_addr_issue", mem_addr, a);
        chk("m_halted_issue", halted, 0);
        chk("m_opcode", instr_opcode, opc);
        chk("m_operand", instr_operand, (len == 2) ? mem[8'(m_pc + 8'd1)] : 8'h00);
        chk("m_ipc", instr_pc, m_pc);
        chk("m_long", instr_long, (len == 2) ? 1 : 0);
      end
      // Advance to the next cycle under the inputs present at this edge.
      if (redirect_valid) begin
        m_pc   = redirect_pc;
        m_age  = 0;
        m_halt = 1'b0;
      end else if (!m_halt) begin
        if (m_age < len) m_age++;
        else if (instr_ready) begin
          if (opc == 8'hFF) m_halt = 1'b1;
          m_pc  = m_pc + 8'(len);
          m_age = 0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h85;
    mem[8'h02] = 8'h3C;
    mem[8'h03] = 8'h86;
    mem[8'h04] = 8'h11;
    mem[8'h05] = 8'hFF;
    mem[8'h06] = 8'h33;
    mem[8'h10] = 8'h04;
    mem[8'h40] = 8'h21;
    mem[8'hFF] = 8'h80;

    repeat (2) tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_opcode", instr_opcode, 0);
    chk("rst_operand", instr_operand, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_long", instr_long, 0);
    reset = 1'b0;

    // 1-byte instruction at 0
    chk("c0_addr", mem_addr, 8'h00);
    chk("c0_re", mem_re, 1);
    tick();
    chk("c1_valid", instr_valid, 1);
    chk("c1_opcode", instr_opcode, 8'h12);
    chk("c1_operand", instr_operand, 8'h00);
    chk("c1_ipc", instr_pc, 8'h00);
    chk("c1_long", instr_long, 0);
    tick();
    chk("c2_addr", mem_addr, 8'h01);
    chk("c2_valid", instr_valid, 0);

    // 2-byte instruction at 1, then a 4-cycle stall
    tick();
    chk("c3_addr", mem_addr, 8'h02);
    chk("c3_re", mem_re, 1);
    tick();
    chk("c4_valid", instr_valid, 1);
    chk("c4_opcode", instr_opcode, 8'h85);
    chk("c4_operand", instr_operand, 8'h3C);
    chk("c4_ipc", instr_pc, 8'h01);
    chk("c4_long", instr_long, 1);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", instr_valid, 1);
      chk("stall_opcode", instr_opcode, 8'h85);
      chk("stall_operand", instr_operand, 8'h3C);
      chk("stall_re", mem_re, 0);
      chk("stall_addr", mem_addr, 8'h03);
      tick();
    end
    instr_ready = 1'b1;
    chk("c8_valid", instr_valid, 1);
    tick();
    chk("c9_valid", instr_valid, 0);
    chk("c9_addr", mem_addr, 8'h03);

    // Redirect during FETCH_ARG
    tick();
    chk("c10_addr", mem_addr, 8'h04);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("rd_addr", mem_addr, 8'h40);
    chk("rd_valid", instr_valid, 0);
    tick();
    chk("rd_bvalid", instr_valid, 1);
    chk("rd_ipc", instr_pc, 8'h40);
    chk("rd_opcode", instr_opcode, 8'h21);

    // Wrap-around: 2-byte instruction at 0xFF
    tick();
    chk("c13_addr", mem_addr, 8'h41);
    mem[8'h00]     = 8'h07;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr_ff", mem_addr, 8'hFF);
    tick();
    chk("wr_addr_00", mem_addr, 8'h00);
    chk("wr_re", mem_re, 1);
    tick();
    chk("wr_valid", instr_valid, 1);
    chk("wr_opcode", instr_opcode, 8'h80);
    chk("wr_operand", instr_operand, 8'h07);
    chk("wr_ipc", instr_pc, 8'hFF);
    chk("wr_long", instr_long, 1);
    tick();
    chk("wr_next_addr", mem_addr, 8'h01);

    // HALT at 5 (bit 7 set, so it carries an operand byte)
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    tick();
    redirect_valid = 1'b0;
    chk("h_addr5", mem_addr, 8'h05);
    tick();
    tick();
    chk("h_valid", instr_valid, 1);
    chk("h_opcode", instr_opcode, 8'hFF);
    chk("h_operand", instr_operand, 8'h33);
    tick();
    chk("h_halted", halted, 1);
    chk("h_re", mem_re, 0);
    chk("h_valid0", instr_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h_stay_halted", halted, 1);
      chk("h_stay_valid", instr_valid, 0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk("h_exit_halted", halted, 0);
    chk("h_exit_addr", mem_addr, 8'h10);
    chk("h_exit_re", mem_re, 1);
    tick();
    chk("h_exit_opcode", instr_opcode, 8'h04);
    chk("h_exit_ipc", instr_pc, 8'h10);

    // Reset while in ISSUE
    instr_ready = 1'b0;
    reset       = 1'b1;
    tick();
    chk("ri_valid", instr_valid, 0);
    chk("ri_ipc", instr_pc, 8'h00);
    chk("ri_addr", mem_addr, 8'h00);
    reset = 1'b0;
    chk("ri_re", mem_re, 1);

    // Redirect coinciding with HALT delivery cancels the halt
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("hc_opcode", instr_opcode, 8'hFF);
    chk("hc_valid", instr_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk("hc_halted", halted, 0);
    chk("hc_addr", mem_addr, 8'h10);
    chk("hc_re", mem_re, 1);

    // Randomized traffic
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if ($urandom_range(11) == 0) mem[i] = 8'hFF;
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      instr_ready    = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc    = 8'($urandom);
      reset          = ($urandom_range(199) == 0);
      tick();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
